// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, DATA_WIDTH+1 cycles per result.
// Optional signed mode is enabled by defining SEQ_DIVIDER_SIGNED_EN (adds the is_signed port).
module seq_divider #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic                  is_signed,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | shift-subtract steps, then result publish on the final edge
    // S_DONE | results valid, done pulse; start accepted here too
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_acc_q, rem_acc_d;
    logic [DATA_WIDTH-1:0] quo_acc_q, quo_acc_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    logic                  sign_a, sign_b;
    logic [DATA_WIDTH-1:0] mag_a, mag_b;
    logic [DATA_WIDTH:0]   shifted, diff;
    logic                  borrow;

    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        sign_a = is_signed & dividend[DATA_WIDTH-1];
        sign_b = is_signed & divisor[DATA_WIDTH-1];
`else
        sign_a = 1'b0;
        sign_b = 1'b0;
`endif
        mag_a = sign_a ? -dividend : dividend;
        mag_b = sign_b ? -divisor  : divisor;

        // Trial subtract on DATA_WIDTH+1 bits; the top bit is the borrow-out.
        shifted = {rem_acc_q, quo_acc_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, div_q};
        borrow  = diff[DATA_WIDTH];

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_acc_d   = rem_acc_q;
        quo_acc_d   = quo_acc_q;
        div_d       = div_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_RUN: begin
                if (cnt_q == CW'(DATA_WIDTH)) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = neg_quo_q ? -quo_acc_q : quo_acc_q;
                    remainder_d = neg_rem_q ? -rem_acc_q : rem_acc_q;
                    dbz_d       = 1'b0;
                end else begin
                    rem_acc_d = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
                    quo_acc_d = (quo_acc_q << 1) | {{(DATA_WIDTH-1){1'b0}}, ~borrow};
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    cnt_d     = '0;
                    rem_acc_d = '0;
                    quo_acc_d = mag_a;
                    div_d     = mag_b;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_acc_q   <= '0;
            quo_acc_q   <= '0;
            div_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_acc_q   <= rem_acc_d;
            quo_acc_q   <= quo_acc_d;
            div_q       <= div_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared every cycle,
// plus directed cases with literal expectations. Signed cases run when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;
    localparam int W = 64;
    localparam int LAT = W + 1;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         sgn = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_divider #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .is_signed(sgn),
`endif
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the division rules.
    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic z);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == MIN_VAL && b == '1) begin
            q = MIN_VAL; r = '0;
        end else begin
            q = sa / sb; r = sa % sb;
        end
    endfunction

    // Model: expected outputs after each rising edge.
    int           remaining = 0;
    logic [W-1:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] pq, pr;
        logic         pz;
        if (reset) begin
            remaining = 0;
            m_q = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    m_q = pend_q; m_r = pend_r; m_dbz = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (start) begin
                model_div(dividend, divisor, sgn, pq, pr, pz);
                if (pz) begin
                    m_q = pq; m_r = pr; m_dbz = 1'b1; m_done = 1'b1; m_busy = 1'b0;
                end else begin
                    pend_q = pq; pend_r = pr; remaining = LAT; m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_dbz);
        end
    end

    // Start pulse: returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b; sgn = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        @(negedge clk);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        int lat, ndone;
        logic [W-1:0] a, b;
        logic s;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        start_op(100, 7, 1'b0);
        wait_done(lat);
        chk("lat_100_7", lat, LAT);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        chk("z_100_7", div_by_zero, 0);

        start_op(5, 0, 1'b0);
        wait_done(lat);
        chk("lat_div0", lat, 0);
        chk("q_div0", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("r_div0", remainder, 5);
        chk("z_div0", div_by_zero, 1);

        start_op(9, 4, 1'b0);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; dividend = 50; divisor = 5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat);
        chk("lat_ignore", lat, LAT - 11);
        chk("q_9_4", quotient, 2);
        chk("r_9_4", remainder, 1);
        chk("z_9_4", div_by_zero, 0);

        start_op(1000, 3, 1'b0);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        start_op(20, 6, 1'b0);
        wait_done(lat);
        chk("q_20_6", quotient, 3);
        chk("r_20_6", remainder, 2);

        @(posedge clk); #1;
        start = 1'b1; dividend = '1; divisor = 1; sgn = 1'b0;
        @(posedge clk);
        wait_done(lat);
        chk("lat_b2b_first", lat, LAT);
        chk("q_b2b_first", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("r_b2b_first", remainder, 0);
        dividend = 7; divisor = 7;
        @(posedge clk); #1 start = 1'b0;
        wait_done(lat);
        chk("lat_b2b_second", lat, LAT);
        chk("q_b2b_second", quotient, 1);
        chk("r_b2b_second", remainder, 0);

        if (SIGNED_BUILD) begin
            start_op(64'hFFFF_FFFF_FFFF_FFF9, 2, 1'b1);
            wait_done(lat);
            chk("q_s_m7_2", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
            chk("r_s_m7_2", remainder, 64'hFFFF_FFFF_FFFF_FFFF);
            start_op(MIN_VAL, '1, 1'b1);
            wait_done(lat);
            chk("lat_s_min", lat, LAT);
            chk("q_s_min", quotient, MIN_VAL);
            chk("r_s_min", remainder, 0);
            chk("z_s_min", div_by_zero, 0);
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 4);
            case (sel)
                0:       b = '0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = {32'h0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            s = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
            start_op(a, b, s);
            if (b != '0 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 50)) @(posedge clk);
                #1 start = 1'b1; dividend = {$urandom, $urandom}; divisor = 64'($urandom);
                @(posedge clk); #1 start = 1'b0;
            end
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
